// File: rtl/coin_credit_controller_pkg.sv
// Shared definitions for the coin credit controller: denominations, prices, states.
// Coin values 100/500/1000, item prices 400/500/1000/2000.
package coin_credit_controller_pkg;

    localparam int unsigned kNumCoins = 3;
    localparam int unsigned kNumItems = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RETURN = 2'd2
    } state_e;

    function automatic logic [31:0] coin_value(input int idx);
        case (idx)
            0:       return 32'd100;
            1:       return 32'd500;
            2:       return 32'd1000;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] item_price(input int idx);
        case (idx)
            0:       return 32'd400;
            1:       return 32'd500;
            2:       return 32'd1000;
            3:       return 32'd2000;
            default: return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/coin_credit_controller_change_selector.sv
// Greedy change pick: largest coin not exceeding the credit, as one-hot plus value.
// o_short flags a non-zero credit smaller than every coin.
module coin_credit_controller_change_selector
    import coin_credit_controller_pkg::*;
#(
    parameter int unsigned NUM_COINS = kNumCoins,
    parameter int unsigned CREDIT_W  = 16
) (
    input  logic [CREDIT_W-1:0]  i_credit,
    output logic [NUM_COINS-1:0] o_coin,
    output logic [CREDIT_W-1:0]  o_value,
    output logic                 o_short
);

    logic [CREDIT_W-1:0] w_val;

    always_comb begin
        o_coin  = '0;
        o_value = '0;
        w_val   = '0;
        for (int i = 0; i < int'(NUM_COINS); i++) begin
            w_val = CREDIT_W'(coin_value(i));
            if (w_val <= i_credit && w_val > o_value) begin
                o_coin    = '0;
                o_coin[i] = 1'b1;
                o_value   = w_val;
            end
        end
        o_short = (o_coin == '0) && (i_credit != '0);
    end

endmodule

// File: rtl/coin_credit_controller.sv
// Credit accumulator, vend debit, wait timer and one-coin-per-cycle change return.
// Define VM_TRIGGER_RETURN_EN to add the manual i_trigger_return request.
module coin_credit_controller
    import coin_credit_controller_pkg::*;
#(
    parameter int unsigned NUM_COINS   = kNumCoins,
    parameter int unsigned NUM_ITEMS   = kNumItems,
    parameter int unsigned CREDIT_W    = 16,
    parameter int unsigned WAIT_CYCLES = 100,
    parameter int unsigned WAIT_W      = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
`ifdef VM_TRIGGER_RETURN_EN
    input  logic                 i_trigger_return,
`endif
    input  logic [NUM_COINS-1:0] i_input_coin,
    input  logic [NUM_ITEMS-1:0] i_select_item,
    output logic [NUM_ITEMS-1:0] o_available_item,
    output logic [NUM_ITEMS-1:0] o_output_item,
    output logic [NUM_COINS-1:0] o_return_coin,
    output logic [CREDIT_W-1:0]  o_credit,
    output logic [WAIT_W-1:0]    wait_time,
    output logic                 o_busy
);

    localparam int unsigned XW = CREDIT_W + 1;
    localparam logic [WAIT_W-1:0] WAIT_RELOAD = WAIT_W'(WAIT_CYCLES);

    state_e                r_state, r_state_nx;
    logic [CREDIT_W-1:0]   r_credit, r_credit_nx;
    logic [WAIT_W-1:0]     r_wait, r_wait_nx;
    logic [NUM_ITEMS-1:0]  r_output_item, r_output_item_nx;
    logic [NUM_COINS-1:0]  r_return_coin, r_return_coin_nx;

    logic [CREDIT_W-1:0]   w_coin_val, w_price, w_pick_val;
    logic [NUM_COINS-1:0]  w_pick_coin;
    logic [XW-1:0]         w_sum;
    logic                  w_pick_short, w_coin_ok, w_ovf;
    logic                  w_accept, w_vend, w_trig;

    coin_credit_controller_change_selector #(
        .NUM_COINS (NUM_COINS),
        .CREDIT_W  (CREDIT_W)
    ) u_sel (
        .i_credit (r_credit),
        .o_coin   (w_pick_coin),
        .o_value  (w_pick_val),
        .o_short  (w_pick_short)
    );

    always_comb begin
        w_coin_val = '0;
        w_price    = '0;
        for (int i = 0; i < int'(NUM_COINS); i++)
            if (i_input_coin[i]) w_coin_val = w_coin_val | CREDIT_W'(coin_value(i));
        for (int i = 0; i < int'(NUM_ITEMS); i++)
            if (i_select_item[i]) w_price = w_price | CREDIT_W'(item_price(i));
    end

    always_comb begin
        o_available_item = '0;
        for (int i = 0; i < int'(NUM_ITEMS); i++)
            o_available_item[i] = XW'(r_credit) >= XW'(item_price(i));
    end

    assign w_sum     = XW'(r_credit) + XW'(w_coin_val);
    assign w_ovf     = w_sum > XW'({CREDIT_W{1'b1}});
    assign w_coin_ok = $onehot(i_input_coin) && (r_state != ST_RETURN);
    assign w_accept  = w_coin_ok && !w_ovf;
    assign w_vend    = $onehot(i_select_item) && (r_state != ST_RETURN)
                       && (r_credit >= w_price);

`ifdef VM_TRIGGER_RETURN_EN
    assign w_trig = i_trigger_return && (r_state == ST_ACTIVE) && (r_credit != '0);
`else
    assign w_trig = 1'b0;
`endif

    always_comb begin
        r_state_nx       = r_state;
        r_credit_nx      = r_credit;
        r_wait_nx        = r_wait;
        r_output_item_nx = '0;
        r_return_coin_nx = '0;
        unique case (r_state)
            ST_IDLE, ST_ACTIVE: begin
                if (w_trig) begin
                    r_state_nx = ST_RETURN;
                end else begin
                    r_credit_nx = r_credit + (w_accept ? w_coin_val : '0)
                                  - (w_vend ? w_price : '0);
                    if (w_vend) r_output_item_nx = i_select_item;
                    // Over-range coin is handed straight back
                    if (w_coin_ok && w_ovf) r_return_coin_nx = i_input_coin;
                    if (r_credit_nx == '0) begin
                        r_state_nx = ST_IDLE;
                        r_wait_nx  = WAIT_RELOAD;
                    end else if (w_accept || w_vend) begin
                        r_state_nx = ST_ACTIVE;
                        r_wait_nx  = WAIT_RELOAD;
                    end else if (r_state == ST_ACTIVE) begin
                        if (r_wait == '0) r_state_nx = ST_RETURN;
                        else r_wait_nx = r_wait - WAIT_W'(1);
                    end
                end
            end
            ST_RETURN: begin
                r_return_coin_nx = w_pick_coin;
                r_credit_nx      = r_credit - w_pick_val;
                if (w_pick_short || r_credit_nx == '0) begin
                    r_credit_nx = '0;
                    r_state_nx  = ST_IDLE;
                    r_wait_nx   = WAIT_RELOAD;
                end
            end
            default: begin
                r_state_nx  = ST_IDLE;
                r_credit_nx = '0;
                r_wait_nx   = WAIT_RELOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_credit      <= '0;
            r_wait        <= WAIT_RELOAD;
            r_output_item <= '0;
            r_return_coin <= '0;
        end else begin
            r_state       <= r_state_nx;
            r_credit      <= r_credit_nx;
            r_wait        <= r_wait_nx;
            r_output_item <= r_output_item_nx;
            r_return_coin <= r_return_coin_nx;
        end
    end

    assign o_output_item = r_output_item;
    assign o_return_coin = r_return_coin;
    assign o_credit      = r_credit;
    assign wait_time     = r_wait;
    assign o_busy        = (r_state == ST_RETURN);

endmodule
